// File: rtl/ctrl_pipeline_pkg.sv
// Shared control-bundle types for the ID->EX->MEM->WB control pipeline.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package ctrl_pipeline_pkg;

    localparam int CP_REG_ADDR_W = 5;

    // ALU operation selected by the decoder, consumed in EX
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLT = 4'd5,
        ALU_SLL = 4'd6,
        ALU_SRL = 4'd7,
        ALU_SRA = 4'd8
    } alu_op_e;

    // p2: fields used inside ID only (immediate select, jump decode); never stored
    typedef struct packed {
        logic       is_jump;
        logic       is_jalr;
        logic [2:0] imm_sel;
    } p2_id_t;

    // p3: fields peeled off in EX
    typedef struct packed {
        alu_op_e alu_ctrl;
        logic    alu_src;
    } p3_ex_t;

    // p4: fields peeled off in MEM
    typedef struct packed {
        logic is_branch;
        logic mem_rd_en;
        logic mem_wr_en;
        logic is_mem_to_reg;
    } p4_mem_t;

    // p5: fields peeled off in WB
    typedef struct packed {
        logic reg_wr_en;
    } p5_wb_t;

    // Full decoder bundle for one instruction
    typedef struct packed {
        p2_id_t  p2;
        p3_ex_t  p3;
        p4_mem_t p4;
        p5_wb_t  p5;
    } cpu_ctrl_t;

    // Per-stage identity tag travelling alongside the control fields
    typedef struct packed {
        logic                     valid;
        logic [CP_REG_ADDR_W-1:0] rd;
    } stage_tag_t;

endpackage

// File: rtl/ctrl_pipeline_if.sv
// Decoder-side inputs and per-stage control outputs of the control pipeline.
// Latency: n/a (wiring bundle).
// Backpressure: i_hold freezes the pipe; o_stall_id / o_flush_id steer IF/ID.
interface ctrl_pipeline_if #(
    parameter int REG_ADDR_W = 5
);
    import ctrl_pipeline_pkg::*;

    cpu_ctrl_t               i_ctrl;
    logic                    i_id_valid;
    logic [REG_ADDR_W-1:0]   i_id_rd;
    logic [REG_ADDR_W-1:0]   i_id_rs1;
    logic [REG_ADDR_W-1:0]   i_id_rs2;
    logic                    i_hold;
    logic                    i_redirect;

    logic                    o_stall_id;
    logic                    o_flush_id;
    p3_ex_t                  o_ex_ctrl;
    logic                    o_ex_valid;
    logic [REG_ADDR_W-1:0]   o_ex_rd;
    p4_mem_t                 o_mem_ctrl;
    logic                    o_mem_valid;
    logic [REG_ADDR_W-1:0]   o_mem_rd;
    p5_wb_t                  o_wb_ctrl;
    logic                    o_wb_valid;
    logic [REG_ADDR_W-1:0]   o_wb_rd;

    // Decoder / front-end side
    modport master (
        output i_ctrl, i_id_valid, i_id_rd, i_id_rs1, i_id_rs2, i_hold, i_redirect,
        input  o_stall_id, o_flush_id,
        input  o_ex_ctrl, o_ex_valid, o_ex_rd,
        input  o_mem_ctrl, o_mem_valid, o_mem_rd,
        input  o_wb_ctrl, o_wb_valid, o_wb_rd
    );

    // Control pipeline side
    modport slave (
        input  i_ctrl, i_id_valid, i_id_rd, i_id_rs1, i_id_rs2, i_hold, i_redirect,
        output o_stall_id, o_flush_id,
        output o_ex_ctrl, o_ex_valid, o_ex_rd,
        output o_mem_ctrl, o_mem_valid, o_mem_rd,
        output o_wb_ctrl, o_wb_valid, o_wb_rd
    );

endinterface

// File: rtl/ctrl_pipeline_hazard_detect.sv
// Load-use compare between the instruction in EX and the sources of the ID instruction.
// Latency: combinational.
// Backpressure: none; the caller decides whether a hit becomes a stall.
module ctrl_pipeline_hazard_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_ex_valid,
    input  logic                  i_ex_mem_rd_en,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_id_valid,
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    output logic                  o_hit
);

    logic w_rs_match;

    // A load in EX whose result is read by ID; x0 is hard-wired and never forwards a hazard
    always_comb begin
        w_rs_match = (i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2);
        o_hit      = i_ex_valid && i_ex_mem_rd_en && (i_ex_rd != '0) && w_rs_match && i_id_valid;
    end

endmodule

// File: rtl/ctrl_pipeline.sv
// Carries decoder control ID->EX->MEM->WB, peeling field groups per stage; load-use stall and redirect flush.
// Latency: ID fields appear on o_ex_* after 1 clk, o_mem_* after 2, o_wb_* after 3.
// Backpressure: i_hold freezes every stage; load-use stalls IF/ID for 1 clk; redirect flushes IF/ID.
module ctrl_pipeline
    import ctrl_pipeline_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter bit HAZARD_EN  = 1'b1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    ctrl_pipeline_if.slave bus
);

    // ID/EX stage register
    p3_ex_t                r_ex_p3;
    p4_mem_t               r_ex_p4;
    p5_wb_t                r_ex_p5;
    logic [REG_ADDR_W-1:0] r_ex_rd;
    logic                  r_ex_valid;

    // EX/MEM stage register
    p4_mem_t               r_mem_p4;
    p5_wb_t                r_mem_p5;
    logic [REG_ADDR_W-1:0] r_mem_rd;
    logic                  r_mem_valid;

    // MEM/WB stage register
    p5_wb_t                r_wb_p5;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic                  r_wb_valid;

    logic w_hit;
    logic w_stall;
    logic w_flush;
    logic w_idex_load;
    logic w_unused_p2;

    // p2 is consumed by the decoder's own ID logic and is deliberately not carried
    assign w_unused_p2 = ^bus.i_ctrl.p2;

    ctrl_pipeline_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard (
        .i_ex_valid     (r_ex_valid),
        .i_ex_mem_rd_en (r_ex_p4.mem_rd_en),
        .i_ex_rd        (r_ex_rd),
        .i_id_valid     (bus.i_id_valid),
        .i_id_rs1       (bus.i_id_rs1),
        .i_id_rs2       (bus.i_id_rs2),
        .o_hit          (w_hit)
    );

    // Priority: reset > hold > redirect > load-use > normal advance
    always_comb begin
        w_flush = 1'b0;
        w_stall = 1'b0;
        if (i_rst_n && !bus.i_hold) begin
            if (bus.i_redirect) begin
                w_flush = 1'b1;
            end else if (HAZARD_EN && w_hit) begin
                w_stall = 1'b1;
            end
        end
        // Only a real, unflushed, unstalled ID instruction enters EX; everything else is a bubble
        w_idex_load = bus.i_id_valid && !bus.i_redirect && !w_stall;
    end

    // ID/EX: load the ID instruction or a bubble; frozen while held
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ex_p3    <= '0;
            r_ex_p4    <= '0;
            r_ex_p5    <= '0;
            r_ex_rd    <= '0;
            r_ex_valid <= 1'b0;
        end else if (!bus.i_hold) begin
            if (w_idex_load) begin
                r_ex_p3    <= bus.i_ctrl.p3;
                r_ex_p4    <= bus.i_ctrl.p4;
                r_ex_p5    <= bus.i_ctrl.p5;
                r_ex_rd    <= bus.i_id_rd;
                r_ex_valid <= 1'b1;
            end else begin
                r_ex_p3    <= '0;
                r_ex_p4    <= '0;
                r_ex_p5    <= '0;
                r_ex_rd    <= '0;
                r_ex_valid <= 1'b0;
            end
        end
    end

    // EX/MEM: always advances from EX (the resolving branch keeps moving on redirect)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem_p4    <= '0;
            r_mem_p5    <= '0;
            r_mem_rd    <= '0;
            r_mem_valid <= 1'b0;
        end else if (!bus.i_hold) begin
            r_mem_p4    <= r_ex_p4;
            r_mem_p5    <= r_ex_p5;
            r_mem_rd    <= r_ex_rd;
            r_mem_valid <= r_ex_valid;
        end
    end

    // MEM/WB: always advances from MEM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wb_p5    <= '0;
            r_wb_rd    <= '0;
            r_wb_valid <= 1'b0;
        end else if (!bus.i_hold) begin
            r_wb_p5    <= r_mem_p5;
            r_wb_rd    <= r_mem_rd;
            r_wb_valid <= r_mem_valid;
        end
    end

    assign bus.o_stall_id  = w_stall;
    assign bus.o_flush_id  = w_flush;
    assign bus.o_ex_ctrl   = r_ex_p3;
    assign bus.o_ex_valid  = r_ex_valid;
    assign bus.o_ex_rd     = r_ex_rd;
    assign bus.o_mem_ctrl  = r_mem_p4;
    assign bus.o_mem_valid = r_mem_valid;
    assign bus.o_mem_rd    = r_mem_rd;
    assign bus.o_wb_ctrl   = r_wb_p5;
    assign bus.o_wb_valid  = r_wb_valid;
    assign bus.o_wb_rd     = r_wb_rd;

endmodule
